// File: rtl/bram_arbiter_2port.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency RAM, one access per clock.
// Define BRAM_ARB_CLEAR_EN to zero words 0..CLEAR_DEPTH-1 after every reset (busy meanwhile).
module bram_arbiter_2port #(
   parameter int unsigned ADDR_WIDTH  = 23,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ROUND_ROBIN = 1,
   parameter int unsigned CLEAR_DEPTH = 65536
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_din,
   output logic                  a_ack,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_dout,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_din,
   output logic                  b_ack,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_dout,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  busy
);

   localparam bit RrEn = (ROUND_ROBIN != 0);

   logic                  run;
   logic                  init_active;
   logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_ARB_CLEAR_EN
   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_q, clr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StInit;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      if (state_q == StInit) begin
         clr_d = clr_q + 1'b1;
         if (clr_q == ADDR_WIDTH'(CLEAR_DEPTH - 1)) begin
            state_d = StRun;
            clr_d   = '0;
         end
      end
   end

   assign init_active = (state_q == StInit);
   assign run         = ~init_active;
   assign clr_addr    = clr_q;
`else
   logic unused_clear_depth;
   assign unused_clear_depth = ^CLEAR_DEPTH;
   assign init_active        = 1'b0;
   assign run                = 1'b1;
   assign clr_addr           = '0;
`endif

   assign busy = init_active;

   // last_b_q = 1 means B won the most recent contended cycle, so A wins the next tie.
   logic                  last_b_q, last_b_d;
   logic                  grant_a, grant_b;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic                  tag1_v_q, tag1_v_d, tag1_b_q, tag1_b_d;
   logic                  tag2_v_q, tag2_b_q;
   logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
   logic [DATA_WIDTH-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (run && !reset) begin
         if (a_req && b_req) begin
            if (RrEn && !last_b_q) grant_b = 1'b1;
            else                   grant_a = 1'b1;
         end else begin
            grant_a = a_req;
            grant_b = b_req;
         end
      end
   end

   always_comb begin
      last_b_d   = last_b_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      if (RrEn && run && a_req && b_req) last_b_d = grant_b;
      if (init_active) begin
         mem_we_d   = 1'b1;
         mem_addr_d = clr_addr;
         mem_din_d  = '0;
      end else if (grant_a) begin
         mem_we_d   = a_we;
         mem_addr_d = a_addr;
         mem_din_d  = a_din;
      end else if (grant_b) begin
         mem_we_d   = b_we;
         mem_addr_d = b_addr;
         mem_din_d  = b_din;
      end
      // Owner tag follows the read: stage 1 aligns with mem_*, stage 2 with mem_dout.
      tag1_v_d   = (grant_a & ~a_we) | (grant_b & ~b_we);
      tag1_b_d   = grant_b;
      a_rvalid_d = tag2_v_q & ~tag2_b_q;
      b_rvalid_d = tag2_v_q & tag2_b_q;
      a_dout_d   = a_rvalid_d ? mem_dout : a_dout_q;
      b_dout_d   = b_rvalid_d ? mem_dout : b_dout_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_b_q   <= 1'b1;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         tag1_v_q   <= 1'b0;
         tag1_b_q   <= 1'b0;
         tag2_v_q   <= 1'b0;
         tag2_b_q   <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_dout_q   <= '0;
         b_dout_q   <= '0;
      end else begin
         last_b_q   <= last_b_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         tag1_v_q   <= tag1_v_d;
         tag1_b_q   <= tag1_b_d;
         tag2_v_q   <= tag1_v_q;
         tag2_b_q   <= tag1_b_q;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_dout_q   <= a_dout_d;
         b_dout_q   <= b_dout_d;
      end
   end

   assign a_ack    = grant_a;
   assign b_ack    = grant_b;
   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_dout   = a_dout_q;
   assign b_dout   = b_dout_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_bram_arbiter_2port.sv
// Randomized bench for bram_arbiter_2port: a transaction-level model predicts grants,
// RAM command stream and per-owner read returns; a plain RAM model closes the loop.
module tb_bram_arbiter_2port;

   localparam int unsigned AW = 23;
   localparam int unsigned DW = 16;
   localparam int unsigned RR = 1;
   localparam int unsigned CD = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_din = '0, b_din = '0;
   logic          a_ack, a_rvalid, b_ack, b_rvalid, mem_we, busy;
   logic [DW-1:0] a_dout, b_dout, mem_din, mem_dout;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   bram_arbiter_2port #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ROUND_ROBIN(RR),
      .CLEAR_DEPTH(CD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .a_req   (a_req),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_din   (a_din),
      .a_ack   (a_ack),
      .a_rvalid(a_rvalid),
      .a_dout  (a_dout),
      .b_req   (b_req),
      .b_we    (b_we),
      .b_addr  (b_addr),
      .b_din   (b_din),
      .b_ack   (b_ack),
      .b_rvalid(b_rvalid),
      .b_dout  (b_dout),
      .mem_we  (mem_we),
      .mem_addr(mem_addr),
      .mem_din (mem_din),
      .mem_dout(mem_dout),
      .busy    (busy)
   );

   // Single-port read-first RAM; low 8 address bits select the word.
   logic [DW-1:0] ram [256] = '{default: '0};
   always @(posedge clk) begin
      mem_dout <= ram[mem_addr[7:0]];
      if (mem_we) ram[mem_addr[7:0]] <= mem_din;
   end

   typedef struct {
      int          due;
      logic [15:0] data;
   } rd_t;

   logic [DW-1:0] ref_mem [256] = '{default: '0};
   rd_t           qa[$], qb[$];
   bit            exp_last_b = 1'b1;
   logic          exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_din = '0;
   int            init_left = 0;
   int            cyc = 0;
   bit            got_a, got_b;
   int            n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // One clock: check everything the model predicts for this cycle, then advance the model.
   task automatic step();
      bit            ga, gb, bsy, exp_rv, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      rd_t           r;
      @(negedge clk);
      bsy = (init_left > 0);
      ga  = !bsy && a_req && (!b_req || RR == 0 || exp_last_b);
      gb  = !bsy && b_req && !ga;
      check_eq("a_ack", a_ack, ga);
      check_eq("b_ack", b_ack, gb);
      check_eq("busy", busy, bsy);
      check_eq("mem_we", mem_we, exp_we);
      check_eq("mem_addr", mem_addr, exp_addr);
      check_eq("mem_din", mem_din, exp_din);
      exp_rv = (qa.size() > 0) && (qa[0].due == cyc);
      check_eq("a_rvalid", a_rvalid, exp_rv);
      if (exp_rv) begin
         check_eq("a_dout", a_dout, qa[0].data);
         void'(qa.pop_front());
      end
      exp_rv = (qb.size() > 0) && (qb[0].due == cyc);
      check_eq("b_rvalid", b_rvalid, exp_rv);
      if (exp_rv) begin
         check_eq("b_dout", b_dout, qb[0].data);
         void'(qb.pop_front());
      end
      if (!bsy && RR != 0 && a_req && b_req) exp_last_b = gb;
      if (bsy) begin
         exp_we   = 1'b1;
         exp_addr = AW'(CD - init_left);
         exp_din  = '0;
         ref_mem[exp_addr[7:0]] = '0;
         init_left--;
      end else if (ga || gb) begin
         we   = ga ? a_we : b_we;
         addr = ga ? a_addr : b_addr;
         din  = ga ? a_din : b_din;
         exp_we   = we;
         exp_addr = addr;
         exp_din  = din;
         if (we) ref_mem[addr[7:0]] = din;
         else begin
            r.due  = cyc + 3;
            r.data = ref_mem[addr[7:0]];
            if (ga) qa.push_back(r);
            else    qb.push_back(r);
         end
      end else begin
         exp_we = 1'b0;
      end
      got_a = ga;
      got_b = gb;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_req = 1'b0;
      b_req = 1'b0;
      #1;
      check_eq("rst_a_ack", a_ack, 0);
      check_eq("rst_b_ack", b_ack, 0);
      check_eq("rst_a_rvalid", a_rvalid, 0);
      check_eq("rst_b_rvalid", b_rvalid, 0);
      check_eq("rst_a_dout", a_dout, 0);
      check_eq("rst_b_dout", b_dout, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_din", mem_din, 0);
      qa.delete();
      qb.delete();
      exp_last_b = 1'b1;
      exp_we     = 1'b0;
      exp_addr   = '0;
      exp_din    = '0;
`ifdef BRAM_ARB_CLEAR_EN
      init_left = CD;
`else
      init_left = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      a_req = 1'b0;
      b_req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] r;
      r[3:0]    = 4'($urandom);
      r[AW-1:4] = ($urandom_range(3) == 0) ? (AW-4)'($urandom) : '0;
      return r;
   endfunction

   initial begin
      int na, nb, rd_i, bound;
      bit a_pend, b_pend;

      do_reset();
      while (init_left > 0) idle(1);

      // A write then read back
      a_req = 1; a_we = 1; a_addr = 23'h10; a_din = 16'h1234; step();
      a_we = 0; step();
      idle(5);

      // B write, A read of the same word on the very next cycle
      b_req = 1; b_we = 1; b_addr = 23'h5; b_din = 16'hBEEF; step();
      b_req = 0; a_req = 1; a_we = 0; a_addr = 23'h5; step();
      idle(5);

      // A held four cycles, B idle
      na = 0;
      for (int i = 0; i < 4; i++) begin
         a_req = 1; a_we = i[0] ? 1'b0 : 1'b1; a_addr = 23'(i + 2); a_din = 16'($urandom);
         step();
         na += int'(a_ack);
      end
      check_eq("a_held_acks", na, 4);
      idle(5);

      // Both read every cycle
      na = 0; nb = 0;
      a_req = 1; b_req = 1; a_we = 0; b_we = 0;
      a_addr = rand_addr(); b_addr = rand_addr();
      for (int i = 0; i < 12; i++) begin
         step();
         if (got_a) begin na++; a_addr = rand_addr(); end
         if (got_b) begin nb++; b_addr = rand_addr(); end
      end
      check_eq("contend_a_acks", na, (RR != 0) ? 6 : 12);
      check_eq("contend_b_acks", nb, (RR != 0) ? 6 : 0);
      idle(5);

      // Random traffic, including requests withdrawn before ack
      a_pend = 0; b_pend = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!a_pend && $urandom_range(3) != 0) begin
            a_pend = 1; a_we = 1'($urandom); a_addr = rand_addr(); a_din = 16'($urandom);
         end else if (a_pend && $urandom_range(15) == 0) a_pend = 0;
         if (!b_pend && $urandom_range(3) != 0) begin
            b_pend = 1; b_we = 1'($urandom); b_addr = rand_addr(); b_din = 16'($urandom);
         end else if (b_pend && $urandom_range(15) == 0) b_pend = 0;
         a_req = a_pend;
         b_req = b_pend;
         step();
         if (got_a) a_pend = 0;
         if (got_b) b_pend = 0;
      end
      idle(5);

      // Reset one clock after an A read ack: the read must never return
      a_req = 1; a_we = 0; a_addr = 23'h10; step();
      do_reset();
      while (init_left > 0) idle(1);
      idle(6);

`ifdef BRAM_ARB_CLEAR_EN
      // Fill with junk, reset, then every cleared word must read back as zero
      for (int i = 0; i < CD; i++) begin
         a_req = 1; a_we = 1; a_addr = 23'(i); a_din = 16'($urandom | 1); step();
      end
      idle(2);
      do_reset();
      rd_i = 0; bound = 0;
      a_req = 1; a_we = 0; a_addr = '0;
      while (rd_i < CD && bound < 80) begin
         step();
         bound++;
         if (got_a) begin rd_i++; a_addr = 23'(rd_i); end
      end
      check_eq("clear_reads_done", rd_i, CD);
      idle(5);
`else
      rd_i = 0; bound = 0;
      if (bound != rd_i) check_eq("unused", bound, rd_i);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
